// File: rtl/rv32i_types.sv
// Shared RV32I types used by the front end: machine word, PC-mux select,
// fetch FSM states and the fetch-queue entry layout.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        pc_plus4 = 2'b00,
        alu_out  = 2'b01,
        alu_mod2 = 2'b10
    } pcmux_sel_t;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        DROP  = 2'b01,
        STALL = 2'b10
    } fetch_state_t;

    typedef struct packed {
        rv32i_word pc;
        rv32i_word instr;
    } fq_entry_t;

    // alu_mod2 clears bit 0 so JALR targets are always halfword aligned
    function automatic rv32i_word redirect_target(input pcmux_sel_t sel,
                                                  input rv32i_word  pc,
                                                  input rv32i_word  data);
        rv32i_word t;
        case (sel)
            alu_out:  t = data;
            alu_mod2: t = {data[31:1], 1'b0};
            default:  t = pc + 32'd4;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch queue of 64-bit {pc, instr} entries with synchronous flush.
// A push while full is accepted only when a pop happens in the same cycle.
module fetch_queue
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [63:0]                push_data,
    input  logic                       pop,
    output logic [63:0]                head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [63:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push && (!full || pop) && !flush;
        pop_ok   = pop && !empty && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // pointers are PW bits wide, so +1 wraps modulo DEPTH
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, fetch FSM (FETCH/DROP/STALL) and a
// decoupling fetch queue. Optional macro FETCH_BYPASS_EN enables empty-queue bypass.
module fetch_unit
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h4000_0060,
    parameter int unsigned FQ_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       icache_read,
    output logic [31:0]                icache_addr,
    input  logic                       icache_resp,
    input  logic [31:0]                icache_rdata,
    input  logic                       redirect,
    input  pcmux_sel_t                 redirect_sel,
    input  logic [31:0]                redirect_data,
    input  logic                       deq_ready,
    output logic                       deq_valid,
    output logic [31:0]                deq_pc,
    output logic [31:0]                deq_instr,
    output logic [$clog2(FQ_DEPTH):0]  fq_count
);

    fetch_state_t state_q, state_d;
    rv32i_word    pc_q, pc_d;
    rv32i_word    drop_addr_q, drop_addr_d;

    logic         fq_push, fq_pop, fq_full, fq_empty, bypass;
    logic [63:0]  fq_head;
    fq_entry_t    push_entry, head_entry;
    int unsigned  cnt_after;

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (fq_push),
        .push_data (push_entry),
        .pop       (fq_pop),
        .head_data (fq_head),
        .count     (fq_count),
        .full      (fq_full),
        .empty     (fq_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            drop_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        cnt_after   = 32'(fq_count) + 32'(fq_push) - 32'(fq_pop);
        if (redirect) begin
            pc_d = redirect_target(redirect_sel, pc_q, redirect_data);
            case (state_q)
                FETCH: begin
                    state_d     = icache_resp ? FETCH : DROP;
                    drop_addr_d = pc_q;
                end
                DROP:    state_d = icache_resp ? FETCH : DROP;
                default: state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (icache_resp) begin
                        pc_d = pc_q + 32'd4;
                        if (cnt_after == FQ_DEPTH) state_d = STALL;
                    end
                end
                DROP:    if (icache_resp) state_d = FETCH;
                default: if (fq_pop) state_d = FETCH;
            endcase
        end
    end

    always_comb begin
        icache_read      = (state_q != STALL);
        // while dropping, the cache still works on the stale request address
        icache_addr      = (state_q == DROP) ? drop_addr_q : pc_q;
        push_entry.pc    = pc_q;
        push_entry.instr = icache_rdata;
        head_entry       = fq_entry_t'(fq_head);
        fq_pop           = !fq_empty && deq_ready;
`ifdef FETCH_BYPASS_EN
        bypass           = (state_q == FETCH) && icache_resp && !redirect &&
                           deq_ready && fq_empty;
`else
        bypass           = 1'b0;
`endif
        fq_push          = (state_q == FETCH) && icache_resp && !redirect && !bypass;
        deq_valid        = (fq_count != '0) || bypass;
        deq_pc           = bypass ? pc_q : head_entry.pc;
        deq_instr        = bypass ? icache_rdata : head_entry.instr;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (default build; bypass case
// only when FETCH_BYPASS_EN is defined).
module tb_fetch_unit;
    import rv32i_types::*;

    localparam logic [31:0] RPC = 32'h4000_0060;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_read;
    logic [31:0] icache_addr;
    logic        icache_resp;
    logic [31:0] icache_rdata;
    logic        redirect;
    pcmux_sel_t  redirect_sel;
    logic [31:0] redirect_data;
    logic        deq_ready;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;
    logic [2:0]  fq_count;

    int vectors = 0;
    int errors  = 0;

    fetch_unit #(
        .RESET_PC (RPC),
        .FQ_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .icache_read   (icache_read),
        .icache_addr   (icache_addr),
        .icache_resp   (icache_resp),
        .icache_rdata  (icache_rdata),
        .redirect      (redirect),
        .redirect_sel  (redirect_sel),
        .redirect_data (redirect_data),
        .deq_ready     (deq_ready),
        .deq_valid     (deq_valid),
        .deq_pc        (deq_pc),
        .deq_instr     (deq_instr),
        .fq_count      (fq_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; icache_resp = 1'b0; icache_rdata = '0; redirect = 1'b0;
        redirect_sel = pc_plus4; redirect_data = '0; deq_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_read",  {31'd0, icache_read}, 32'd1);
        chk("rst_addr",  icache_addr, RPC);
        chk("rst_valid", {31'd0, deq_valid}, 32'd0);
        chk("rst_count", {29'd0, fq_count}, 32'd0);

`ifdef FETCH_BYPASS_EN
        icache_resp = 1'b1; icache_rdata = 32'hB000_0000; deq_ready = 1'b1;
        #1;
        chk("byp_valid", {31'd0, deq_valid}, 32'd1);
        chk("byp_pc",    deq_pc, RPC);
        chk("byp_count", {29'd0, fq_count}, 32'd0);
        step();
        chk("byp_after_count", {29'd0, fq_count}, 32'd0);
        chk("byp_after_addr",  icache_addr, 32'h4000_0064);
        icache_resp = 1'b0; deq_ready = 1'b0;
`else
        // in-order streaming with decode always ready
        deq_ready = 1'b1; icache_resp = 1'b1; icache_rdata = 32'hA000_0000;
        #1;
        chk("lat_no_bypass", {31'd0, deq_valid}, 32'd0);
        step();
        chk("s0_pc",    deq_pc, 32'h4000_0060);
        chk("s0_instr", deq_instr, 32'hA000_0000);
        chk("s0_addr",  icache_addr, 32'h4000_0064);
        icache_rdata = 32'hA000_0001;
        step();
        chk("s1_pc",    deq_pc, 32'h4000_0064);
        chk("s1_instr", deq_instr, 32'hA000_0001);
        chk("s1_count", {29'd0, fq_count}, 32'd1);
        icache_rdata = 32'hA000_0002;
        step();
        chk("s2_pc",    deq_pc, 32'h4000_0068);
        icache_resp = 1'b0;
        step();
        chk("s_drain_valid", {31'd0, deq_valid}, 32'd0);
        chk("s_drain_addr",  icache_addr, 32'h4000_006C);

        // fill to full: four pushes at 6C,70,74,78 then STALL
        deq_ready = 1'b0; icache_resp = 1'b1;
        for (int i = 0; i < 4; i++) begin
            icache_rdata = 32'hC000_0000 + 32'(i);
            step();
        end
        chk("full_count", {29'd0, fq_count}, 32'd4);
        chk("full_read",  {31'd0, icache_read}, 32'd0);
        chk("full_head",  deq_pc, 32'h4000_006C);
        icache_rdata = 32'hDEAD_BEEF;
        step();
        chk("stall_count_hold", {29'd0, fq_count}, 32'd4);
        icache_resp = 1'b0; deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        chk("pop_read",  {31'd0, icache_read}, 32'd1);
        chk("pop_count", {29'd0, fq_count}, 32'd3);
        chk("pop_head",  deq_pc, 32'h4000_0070);
        chk("pop_instr", deq_instr, 32'hC000_0001);
        chk("pop_addr",  icache_addr, 32'h4000_007C);

        // redirect coinciding with resp, queue holds 3
        icache_resp = 1'b1; icache_rdata = 32'h1111_1111;
        redirect = 1'b1; redirect_sel = alu_out; redirect_data = 32'h4000_0200;
        step();
        chk("rr_count", {29'd0, fq_count}, 32'd0);
        chk("rr_valid", {31'd0, deq_valid}, 32'd0);
        chk("rr_addr",  icache_addr, 32'h4000_0200);
        chk("rr_read",  {31'd0, icache_read}, 32'd1);

        // redirect alu_mod2 while waiting -> DROP on stale address
        icache_resp = 1'b0; redirect_sel = alu_mod2; redirect_data = 32'h4000_0101;
        step();
        redirect = 1'b0;
        chk("drop_addr", icache_addr, 32'h4000_0200);
        chk("drop_read", {31'd0, icache_read}, 32'd1);
        icache_resp = 1'b1; icache_rdata = 32'h5555_5555;
        step();
        chk("drop_discard_count", {29'd0, fq_count}, 32'd0);
        chk("drop_new_addr",      icache_addr, 32'h4000_0100);
        icache_rdata = 32'h6666_6666;
        step();
        icache_resp = 1'b0;
        chk("refetch_pc",    deq_pc, 32'h4000_0100);
        chk("refetch_instr", deq_instr, 32'h6666_6666);
        chk("refetch_count", {29'd0, fq_count}, 32'd1);

        // redirect while in DROP (pc_plus4 off the redirected pc)
        redirect = 1'b1; redirect_sel = alu_out; redirect_data = 32'h4000_0300;
        step();
        chk("d2_flush", {29'd0, fq_count}, 32'd0);
        redirect_sel = pc_plus4;
        step();
        redirect = 1'b0;
        chk("d2_stale_addr", icache_addr, 32'h4000_0104);
        icache_resp = 1'b1; icache_rdata = 32'h7777_7777;
        step();
        icache_resp = 1'b0;
        chk("d2_new_addr", icache_addr, 32'h4000_0304);
        chk("d2_count",    {29'd0, fq_count}, 32'd0);

        // reset mid-DROP wins over redirect and resp
        redirect = 1'b1; redirect_sel = alu_out; redirect_data = 32'h4000_0400;
        step();
        chk("d3_stale_addr", icache_addr, 32'h4000_0304);
        rst = 1'b1; icache_resp = 1'b1; redirect_data = 32'h4000_0500;
        step();
        rst = 1'b0; redirect = 1'b0; icache_resp = 1'b0;
        chk("rst2_addr",  icache_addr, RPC);
        chk("rst2_valid", {31'd0, deq_valid}, 32'd0);
        chk("rst2_count", {29'd0, fq_count}, 32'd0);
        chk("rst2_read",  {31'd0, icache_read}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
